// File: rtl/alu_rsp_deserializer.sv
// Deserializer for the ALU serial response line: gathers 11-bit packets into a
// normal response (4 data + 1 CTL) or a single-packet error response.
module alu_rsp_deserializer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sout,
    output logic        rsp_valid,
    output logic [31:0] rsp_C,
    output logic [3:0]  rsp_flags,
    output logic [2:0]  rsp_crc,
    output logic        crc_ok,
    output logic        rsp_err,
    output logic [5:0]  rsp_err_flags,
    output logic        parity_ok,
    output logic        frame_err
);

    localparam int GW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [3:0]      bit_cnt_r;
    logic [2:0]      pkt_idx_r;
    logic [GW-1:0]   gap_cnt_r;
    logic            line_hi_r;
    logic            type_r;
    logic [7:0]      pay_r;
    logic [31:0]     word_r;

    // CRC-3, x^3+x+1, zero init, message shifted in MSB first
    function automatic logic [2:0] crc3_f(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
        end
        return c;
    endfunction

    // Even parity over the whole error payload
    function automatic logic parity_even_f(input logic [7:0] p);
        return ~(^p);
    endfunction

    // Receiver FSM with registered response/error outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            bit_cnt_r     <= 4'd0;
            pkt_idx_r     <= 3'd0;
            gap_cnt_r     <= '0;
            line_hi_r     <= 1'b0;
            type_r        <= 1'b0;
            pay_r         <= 8'd0;
            word_r        <= 32'd0;
            rsp_valid     <= 1'b0;
            rsp_C         <= 32'd0;
            rsp_flags     <= 4'd0;
            rsp_crc       <= 3'd0;
            crc_ok        <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_err_flags <= 6'd0;
            parity_ok     <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            frame_err <= 1'b0;
            line_hi_r <= sout;
            case (state_r)
                IDLE, DONE: begin
                    // line_hi_r gates out a line still low after reset or a bad stop bit
                    if (line_hi_r && !sout) begin
                        state_r   <= SHIFT;
                        bit_cnt_r <= 4'd1;
                        pkt_idx_r <= 3'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    if (bit_cnt_r == 4'd1) begin
                        type_r <= sout;
                    end else if (bit_cnt_r <= 4'd9) begin
                        pay_r <= {pay_r[6:0], sout};
                    end else begin
                        bit_cnt_r <= 4'd0;
                        gap_cnt_r <= '0;
                        if (!sout) begin
                            frame_err <= 1'b1;
                            state_r   <= IDLE;
                        end else if (pkt_idx_r == 3'd0 && type_r) begin
                            if (pay_r[7]) begin
                                rsp_valid     <= 1'b1;
                                rsp_C         <= 32'd0;
                                rsp_flags     <= 4'd0;
                                rsp_crc       <= 3'd0;
                                crc_ok        <= 1'b0;
                                rsp_err       <= 1'b1;
                                rsp_err_flags <= pay_r[6:1];
                                parity_ok     <= parity_even_f(pay_r);
                                state_r       <= DONE;
                            end else begin
                                frame_err <= 1'b1;
                                state_r   <= IDLE;
                            end
                        end else if (pkt_idx_r == 3'd4) begin
                            if (type_r) begin
                                rsp_valid     <= 1'b1;
                                rsp_C         <= word_r;
                                rsp_flags     <= pay_r[6:3];
                                rsp_crc       <= pay_r[2:0];
                                crc_ok        <= (crc3_f({word_r, 1'b0, pay_r[6:3]}) == pay_r[2:0]);
                                rsp_err       <= 1'b0;
                                rsp_err_flags <= 6'd0;
                                parity_ok     <= 1'b0;
                                state_r       <= DONE;
                            end else begin
                                frame_err <= 1'b1;
                                state_r   <= IDLE;
                            end
                        end else if (type_r) begin
                            frame_err <= 1'b1;
                            state_r   <= IDLE;
                        end else begin
                            word_r    <= {word_r[23:0], pay_r};
                            pkt_idx_r <= pkt_idx_r + 3'd1;
                            state_r   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (!sout) begin
                        state_r   <= SHIFT;
                        bit_cnt_r <= 4'd1;
                        gap_cnt_r <= '0;
                    end else if (gap_cnt_r >= GW'(TIMEOUT)) begin
                        frame_err <= 1'b1;
                        state_r   <= IDLE;
                    end else if (gap_cnt_r != {GW{1'b1}}) begin
                        gap_cnt_r <= gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rsp_deserializer.sv
// Scoreboard bench for alu_rsp_deserializer: drives packets on sout, queues the
// expected result of each response and compares when the DUT pulses.
module tb_alu_rsp_deserializer;

    logic        clk;
    logic        rst;
    logic        sout;
    logic        rsp_valid;
    logic [31:0] rsp_C;
    logic [3:0]  rsp_flags;
    logic [2:0]  rsp_crc;
    logic        crc_ok;
    logic        rsp_err;
    logic [5:0]  rsp_err_flags;
    logic        parity_ok;
    logic        frame_err;

    alu_rsp_deserializer #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .sout(sout),
        .rsp_valid(rsp_valid), .rsp_C(rsp_C), .rsp_flags(rsp_flags),
        .rsp_crc(rsp_crc), .crc_ok(crc_ok), .rsp_err(rsp_err),
        .rsp_err_flags(rsp_err_flags), .parity_ok(parity_ok),
        .frame_err(frame_err)
    );

    typedef struct {
        bit          valid;
        int          cyc;
        logic [31:0] c;
        logic [3:0]  fl;
        logic [2:0]  crc;
        bit          cok;
        bit          err;
        logic [5:0]  ef;
        bit          pok;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC as modulo-2 long division of d*x^3 by 1011
    function automatic logic [2:0] ref_crc(input logic [36:0] d);
        logic [39:0] r;
        r = {d, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    task automatic send_bit(input logic b);
        sout = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_pkt(input logic t, input logic [7:0] p, input logic stp);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(p[i]);
        send_bit(stp);
    endtask

    task automatic push_ferr();
        exp_t e;
        e       = held;
        e.valid = 1'b0;
        e.cyc   = cyc;
        sb.push_back(e);
    endtask

    task automatic send_rsp(input logic [31:0] c, input logic [3:0] fl,
                            input logic [2:0] rx, input int gap);
        exp_t e;
        for (int k = 3; k >= 0; k--) begin
            send_pkt(1'b0, c[8*k +: 8], 1'b1);
            idle(gap);
        end
        send_pkt(1'b1, {1'b0, fl, rx}, 1'b1);
        e = '{valid: 1'b1, cyc: cyc, c: c, fl: fl, crc: rx,
              cok: (ref_crc({c, 1'b0, fl}) == rx), err: 1'b0, ef: 6'd0, pok: 1'b0};
        held = e;
        sb.push_back(e);
    endtask

    task automatic send_err(input logic [7:0] p);
        exp_t e;
        send_pkt(1'b1, p, 1'b1);
        e = '{valid: 1'b1, cyc: cyc, c: 32'd0, fl: 4'd0, crc: 3'd0, cok: 1'b0,
              err: 1'b1, ef: p[6:1], pok: ((p[0]+p[1]+p[2]+p[3]+p[4]+p[5]+p[6]+p[7]) % 2 == 0)};
        held = e;
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_C"}, rsp_C, 32'd0);
        chk({tag, "_misc"}, {rsp_valid, frame_err, rsp_flags, rsp_crc, crc_ok,
                             rsp_err, rsp_err_flags, parity_ok}, 32'd0);
    endtask

    // Monitor: pop and compare on every DUT pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && frame_err) chk("both_pulses", 32'd1, 32'd0);
            if (rsp_valid || frame_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {31'd0, rsp_valid}, {31'd0, frame_err});
                    chk("unexpected_any", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("kind_valid", {31'd0, rsp_valid}, {31'd0, mon_e.valid});
                    chk("latency_cyc", cyc, mon_e.cyc);
                    chk("rsp_C", rsp_C, mon_e.c);
                    chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, mon_e.fl});
                    chk("rsp_crc", {29'd0, rsp_crc}, {29'd0, mon_e.crc});
                    chk("crc_ok", {31'd0, crc_ok}, {31'd0, mon_e.cok});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
                    chk("rsp_err_flags", {26'd0, rsp_err_flags}, {26'd0, mon_e.ef});
                    chk("parity_ok", {31'd0, parity_ok}, {31'd0, mon_e.pok});
                end
            end
        end
    end

    initial begin
        held = '{valid: 1'b0, cyc: 0, c: 32'd0, fl: 4'd0, crc: 3'd0, cok: 1'b0,
                 err: 1'b0, ef: 6'd0, pok: 1'b0};
        sout = 1'b0;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        // line still low after reset must be ignored
        repeat (14) send_bit(1'b0);
        idle(2);

        // all-zero response
        send_rsp(32'd0, 4'd0, 3'd0, 0);
        idle(3);
        // wrong CRC
        send_rsp(32'h12345678, 4'd0, 3'b101, 1);
        // back-to-back responses, zero gap
        send_rsp(32'hDEADBEEF, 4'hA, ref_crc({32'hDEADBEEF, 1'b0, 4'hA}), 0);
        send_err(8'h93);
        send_err(8'h92);
        idle(2);

        // stop bit 0 on second data packet
        send_pkt(1'b0, 8'hAA, 1'b1);
        send_pkt(1'b0, 8'h55, 1'b0);
        push_ferr();
        idle(2);
        send_rsp(32'hCAFEF00D, 4'h3, ref_crc({32'hCAFEF00D, 1'b0, 4'h3}), 2);

        // CTL at index 0 with bit7 clear, CTL at index 2, data at index 4
        send_pkt(1'b1, 8'h12, 1'b1);
        push_ferr();
        send_pkt(1'b0, 8'h01, 1'b1);
        send_pkt(1'b0, 8'h02, 1'b1);
        send_pkt(1'b1, 8'h03, 1'b1);
        push_ferr();
        for (int k = 0; k < 5; k++) send_pkt(1'b0, 8'(k), 1'b1);
        push_ferr();
        idle(1);

        // gap timeout: 256 idle cycles fails, 255 passes
        send_pkt(1'b0, 8'h11, 1'b1);
        send_pkt(1'b0, 8'h22, 1'b1);
        idle(256);
        push_ferr();
        idle(2);
        send_rsp(32'h0BADC0DE, 4'h5, 3'd0, 255);

        // random responses with small gaps
        for (int n = 0; n < 6; n++) begin
            logic [31:0] rc;
            logic [3:0]  rf;
            logic [2:0]  rx;
            rc = $urandom;
            rf = 4'($urandom_range(15, 0));
            rx = (n % 2 == 0) ? ref_crc({rc, 1'b0, rf}) : 3'($urandom_range(7, 0));
            send_rsp(rc, rf, rx, $urandom_range(3, 0));
            idle($urandom_range(2, 0));
        end

        // reset during bit 6 of the third packet
        send_pkt(1'b0, 8'h01, 1'b1);
        send_pkt(1'b0, 8'h02, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        held = '{valid: 1'b0, cyc: 0, c: 32'd0, fl: 4'd0, crc: 3'd0, cok: 1'b0,
                 err: 1'b0, ef: 6'd0, pok: 1'b0};
        @(posedge clk);
        #1;
        sout = 1'b1;
        rst  = 1'b0;
        idle(2);
        chk_zero("post_reset");
        send_rsp(32'h89ABCDEF, 4'hF, ref_crc({32'h89ABCDEF, 1'b0, 4'hF}), 0);

        idle(5);
        chk("pending_expected", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
